seq_mult_deser: RTL and testbench
=================================

Name: seq_mult_deser

Overview:
- Downstream stage of the bit-serial sequential multiplier. Collects the P-bit product digits the multiplier emits LSB-first and assembles them into a full product word.
- Sign-extends or zero-extends the assembled word to 2*MAX_WIDTH bits.
- Presents the result on a one-entry valid/ready output buffer to the consumer (accumulator/writeback).

Parameters:
- P, 2, digit width in bits; must match the multiplier's digit width.
- MAX_WIDTH, 16, maximum operand width in bits. Output width is 2*MAX_WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  pulse: new multiplication begins; samples bit_size and signed_mode
- bit_size  input  $clog2(MAX_WIDTH/P)+2  operand width in P-bit digits (1 means a P-bit operand)
- signed_mode  input  1  1 = sign-extend the product, 0 = zero-extend
- in_valid  input  1  digit strobe from the multiplier (its output-update cycle)
- in_digit  input  P  product digit, LSB-first
- busy  output  1  assembly in progress
- out_valid  output  1  product held in the output buffer
- out_ready  input  1  consumer accepts the product
- out_product  output  2*MAX_WIDTH  assembled, extended product
- overrun  output  1  sticky: a completed product was dropped because the buffer was full

Behaviour:
- Reset: every register cleared.
  - busy=0, out_valid=0, out_product=0, overrun=0.
  - Digit counter and assembly register = 0.
- start (synchronous, highest priority):
  - Latches nd = clamp(bit_size), where 0 maps to 1 and values above MAX_WIDTH/P map to MAX_WIDTH/P.
  - Latches signed_mode.
  - Clears the digit counter and assembly register, and clears overrun.
  - Sets busy=1.
  - An in_valid in the same cycle is discarded.
  - out_valid and out_product are NOT affected; a pending result survives start.
- Digit capture: when busy=1, in_valid=1 and start=0:
  - in_digit is written to asm[cnt*P +: P].
  - cnt increments.
  - in_valid while busy=0 is ignored with no state change.
- Completion: the capture cycle with cnt == 2*nd-1.
  - The product width is W = 2*nd*P bits.
  - Extended word: bits [W-1:0] = assembled digits, with the final digit taken directly from in_digit. Bits above W are copies of bit W-1 when signed, else 0.
  - On the same edge, busy<=0 and cnt<=0.
  - The extended word is written to out_product with out_valid<=1, provided the buffer is free.
  - Latency: out_valid rises 1 cycle after the final in_valid.
- Buffer free means out_valid=0, or out_valid=1 with out_ready=1 in the completion cycle (simultaneous handoff: the old product is consumed and the new one loaded, so out_valid stays 1).
- Buffer full at completion (out_valid=1, out_ready=0):
  - The new product is dropped and overrun<=1.
  - out_product and out_valid are unchanged.
- Handshake:
  - Transfer occurs on any edge with out_valid && out_ready.
  - out_valid falls on that edge unless a completion loads a new product in the same cycle.
  - out_product is stable while out_valid=1 && out_ready=0.
- Reset mid-operation: asynchronous clear of all state; the partial product is lost and no out_valid is produced.
- Implementation: no combinational path from in_* to out_*; all outputs registered.

Test Plan:
1. P=2, MAX_WIDTH=16, start with bit_size=2, signed_mode=0; digits 01,10,11,00 on consecutive cycles, out_ready=1 -> one cycle after the 4th digit, out_valid=1 and out_product=0x00000039; busy falls on the same edge.
2. start with bit_size=2, signed_mode=1; digits 10,11,11,11 -> out_product=0xFFFFFFFE; repeating with signed_mode=0 -> 0x000000FE.
3. bit_size=8, 16 digits all 11, signed_mode=0 -> out_product=0xFFFFFFFF; bit_size=9 (clamped to 8) gives the same result after 16 digits.
4. Backpressure: hold out_ready=0 and complete product A=0x39, then product B -> out_product stays 0x00000039, overrun=1. Raising out_ready -> out_valid=0 next cycle. A following start -> overrun=0.
5. Simultaneous: out_valid=1 with product A and out_ready=1 in B's completion cycle -> out_valid stays 1, out_product=B, overrun=0.
6. start after 2 of 4 digits, and again with in_valid=1 in the start cycle -> partial data discarded. The next 4 digits 01,00,00,00 yield 0x00000001. Asserting rst_n=0 mid-assembly clears busy/out_valid immediately.

Source files
------------

// File: rtl/seq_mult_deser.sv
// rtl/seq_mult_deser.sv - collects LSB-first product digits into an extended product word
// Each completed product goes into a one-entry valid/ready output buffer.
module seq_mult_deser #(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_WIDTH/P)+1:0] bit_size,
    input  logic                           signed_mode,
    input  logic                           in_valid,
    input  logic [P-1:0]                   in_digit,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*MAX_WIDTH-1:0]         out_product,
    output logic                           overrun
);

    localparam int MAX_D = MAX_WIDTH / P;
    localparam int ND    = 2 * MAX_D;
    localparam int BW    = $clog2(MAX_D) + 2;
    localparam int CW    = (ND > 1) ? $clog2(ND) : 1;
    localparam int OW    = 2 * MAX_WIDTH;
    localparam logic [BW-1:0] MAX_D_B = BW'(MAX_D);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_last;
    logic          r_signed;
    logic          r_busy;
    logic [OW-1:0] r_asm;
    logic          r_valid;
    logic [OW-1:0] r_product;
    logic          r_overrun;

    logic [BW-1:0] w_nd;
    logic [CW-1:0] w_last_init;
    logic          w_cap;
    logic          w_done;
    logic          w_sign;
    logic          w_free;
    logic [OW-1:0] w_ext;

    always_comb begin
        w_nd = bit_size;
        if (bit_size == '0)
            w_nd = BW'(1);
        else if (bit_size > MAX_D_B)
            w_nd = MAX_D_B;
    end

    // Index of the final digit: a product has twice as many digits as an operand.
    assign w_last_init = CW'({w_nd, 1'b0} - (BW+1)'(1));

    assign w_cap  = r_busy && in_valid && !start;
    assign w_done = w_cap && (r_cnt == r_last);
    assign w_free = !r_valid || out_ready;

    // The final digit carries the product MSB, so it alone decides the extension.
    assign w_sign = r_signed & in_digit[P-1];

    always_comb begin
        w_ext = '0;
        for (int j = 0; j < ND; j++) begin
            if (CW'(j) == r_cnt)
                w_ext[j*P +: P] = in_digit;
            else if (CW'(j) < r_cnt)
                w_ext[j*P +: P] = r_asm[j*P +: P];
            else
                w_ext[j*P +: P] = {P{w_sign}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_last    <= '0;
            r_signed  <= 1'b0;
            r_busy    <= 1'b0;
            r_asm     <= '0;
            r_valid   <= 1'b0;
            r_product <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (r_valid && out_ready)
                r_valid <= 1'b0;

            if (start) begin
                r_last    <= w_last_init;
                r_signed  <= signed_mode;
                r_cnt     <= '0;
                r_asm     <= '0;
                r_overrun <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                if (w_free) begin
                    r_product <= w_ext;
                    r_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_cap) begin
                r_asm[r_cnt*P +: P] <= in_digit;
                r_cnt               <= r_cnt + CW'(1);
            end
        end
    end

    assign busy        = r_busy;
    assign out_valid   = r_valid;
    assign out_product = r_product;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_seq_mult_deser.sv
// tb/tb_seq_mult_deser.sv - bench for seq_mult_deser
module tb_seq_mult_deser;

    localparam int P         = 2;
    localparam int MAX_WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  bit_size;
    logic        signed_mode;
    logic        in_valid;
    logic [1:0]  in_digit;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    seq_mult_deser #(.P(P), .MAX_WIDTH(MAX_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_size   (bit_size),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_digit   (in_digit),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  bs;
        logic        sm;
        int          n;
        logic [31:0] dw;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Product of 2*nd digits read as an integer, then sign- or zero-extended to 32 bits.
    function automatic logic [31:0] model(input logic [4:0] bs, input logic sm, input logic [31:0] dw);
        int     nd;
        int     w;
        longint v;
        nd = (bs == 0) ? 1 : ((bs > 8) ? 8 : int'(bs));
        w  = 2 * nd * P;
        v  = 0;
        for (int k = 0; k < 2 * nd; k++)
            v = v + (longint'(dw[2*k +: 2]) << (2 * k));
        if (sm && v >= (longint'(1) << (w - 1)))
            v = v - (longint'(1) << w);
        return v[31:0];
    endfunction

    function automatic int ndig(input logic [4:0] bs);
        return 2 * ((bs == 0) ? 1 : ((bs > 8) ? 8 : int'(bs)));
    endfunction

    task automatic run(input logic [4:0] bs, input logic sm, input logic [31:0] dw,
                       input int n, input int gaps, input logic rl);
        start       = 1'b1;
        bit_size    = bs;
        signed_mode = sm;
        in_valid    = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps > 0) begin
                repeat ($urandom_range(0, gaps)) begin
                    in_valid = 1'b0;
                    in_digit = 2'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            in_digit = dw[2*k +: 2];
            if (k == n - 1)
                out_ready = rl;
            step();
        end
        in_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{bs: 5'd2,  sm: 1'b0, n: 4,  dw: 32'h0000_0039, exp: 32'h0000_0039};
        vecs[1] = '{bs: 5'd2,  sm: 1'b1, n: 4,  dw: 32'h0000_00FE, exp: 32'hFFFF_FFFE};
        vecs[2] = '{bs: 5'd2,  sm: 1'b0, n: 4,  dw: 32'h0000_00FE, exp: 32'h0000_00FE};
        vecs[3] = '{bs: 5'd8,  sm: 1'b0, n: 16, dw: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
        vecs[4] = '{bs: 5'd9,  sm: 1'b0, n: 16, dw: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
        vecs[5] = '{bs: 5'd0,  sm: 1'b1, n: 2,  dw: 32'h0000_000E, exp: 32'hFFFF_FFFE};
        vecs[6] = '{bs: 5'd1,  sm: 1'b0, n: 2,  dw: 32'h0000_0009, exp: 32'h0000_0009};
        vecs[7] = '{bs: 5'd31, sm: 1'b1, n: 16, dw: 32'h8000_0000, exp: 32'h8000_0000};

        rst_n = 1'b0; start = 1'b0; bit_size = '0; signed_mode = 1'b0;
        in_valid = 1'b0; in_digit = '0; out_ready = 1'b1;
        repeat (2) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_product", out_product, 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        in_valid = 1'b1; in_digit = 2'd3;
        repeat (3) step();
        in_valid = 1'b0;
        chk("idle_digits_busy", 32'(busy), 32'd0);
        chk("idle_digits_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run(vecs[i].bs, vecs[i].sm, vecs[i].dw, vecs[i].n, 0, 1'b1);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_product", i), out_product, vecs[i].exp);
            step();
            chk($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  bs;
            logic        sm;
            logic [31:0] dw;
            bs = 5'($urandom_range(0, 31));
            sm = 1'($urandom);
            dw = $urandom;
            run(bs, sm, dw, ndig(bs), 2, 1'b1);
            chk($sformatf("rnd%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("rnd%0d_product", i), out_product, model(bs, sm, dw));
            step();
        end

        // Backpressure: second product is dropped while the first is held.
        out_ready = 1'b0;
        run(5'd2, 1'b0, 32'h39, 4, 0, 1'b0);
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        run(5'd2, 1'b0, 32'hFE, 4, 0, 1'b0);
        chk("bp_b_product", out_product, 32'h39);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bp_overrun_clr", 32'(overrun), 32'd0);

        // Simultaneous handoff in B's completion cycle.
        out_ready = 1'b0;
        run(5'd2, 1'b0, 32'h39, 4, 0, 1'b0);
        chk("sim_a_product", out_product, 32'h39);
        run(5'd2, 1'b1, 32'hFE, 4, 0, 1'b1);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_product", out_product, 32'hFFFF_FFFE);
        chk("sim_overrun", 32'(overrun), 32'd0);
        step();
        chk("sim_drain", 32'(out_valid), 32'd0);

        // Restart mid-assembly, with a digit in the restart cycle.
        out_ready = 1'b0;
        start = 1'b1; bit_size = 5'd2; signed_mode = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b1; in_digit = 2'd3;
        step();
        step();
        start = 1'b1; in_digit = 2'd3;
        step();
        start = 1'b0;
        in_digit = 2'd1; step();
        in_digit = 2'd0; step();
        step();
        step();
        in_valid = 1'b0;
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_product", out_product, 32'h1);
        chk("restart_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-assembly with a pending product.
        start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1; in_digit = 2'd2;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_product", out_product, 32'd0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; in_digit = 2'd1;
        repeat (3) step();
        in_valid = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
